// File: rtl/ex_stage.sv
// Execute stage: operand select, single-cycle ALU and multiplier, branch/jump
// resolution with misprediction flush, and an iterative radix-2 divider.
module ex_stage #(
    parameter int XLEN          = 32,
    parameter int MISPRED_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [XLEN-1:0]          pc_i,
    input  logic [XLEN-1:0]          rs1_i,
    input  logic [XLEN-1:0]          rs2_i,
    input  logic [XLEN-1:0]          imm_i,
    input  logic [4:0]               alu_op_i,
    input  logic [1:0]               data_origin_i,
    input  logic                     br_sig_i,
    input  logic [2:0]               br_op_i,
    input  logic                     br_pred_i,
    output logic [XLEN-1:0]          alu_res_o,
    output logic [XLEN-1:0]          redirect_pc_o,
    output logic                     mispredict_o,
    output logic                     stall_o,
    output logic [MISPRED_CNT_W-1:0] mispred_cnt_o
);

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_AND    = 5'd2;
    localparam logic [4:0] ALU_OR     = 5'd3;
    localparam logic [4:0] ALU_XOR    = 5'd4;
    localparam logic [4:0] ALU_SLL    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_SLT    = 5'd8;
    localparam logic [4:0] ALU_SLTU   = 5'd9;
    localparam logic [4:0] ALU_LUI    = 5'd10;
    localparam logic [4:0] ALU_MUL    = 5'd11;
    localparam logic [4:0] ALU_MULH   = 5'd12;
    localparam logic [4:0] ALU_MULHSU = 5'd13;
    localparam logic [4:0] ALU_MULHU  = 5'd14;
    localparam logic [4:0] ALU_DIV    = 5'd15;
    localparam logic [4:0] ALU_DIVU   = 5'd16;
    localparam logic [4:0] ALU_REM    = 5'd17;
    localparam logic [4:0] ALU_REMU   = 5'd18;

    localparam logic [1:0] IMM_RS1 = 2'b00;
    localparam logic [1:0] RS2_RS1 = 2'b01;
    localparam logic [1:0] IMM_PC  = 2'b10;

    localparam logic [2:0] BR_BEQ  = 3'd0;
    localparam logic [2:0] BR_BNE  = 3'd1;
    localparam logic [2:0] BR_BLT  = 3'd2;
    localparam logic [2:0] BR_BGE  = 3'd3;
    localparam logic [2:0] BR_BLTU = 3'd4;
    localparam logic [2:0] BR_BGEU = 3'd5;
    localparam logic [2:0] BR_JAL  = 3'd6;
    localparam logic [2:0] BR_JALR = 3'd7;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CNT_W = $clog2(XLEN);

    logic [1:0]      state;
    logic [XLEN-1:0] op_a, op_b;

    always_comb begin
        case (data_origin_i)
            IMM_RS1: begin op_a = rs1_i; op_b = imm_i; end
            IMM_PC:  begin op_a = pc_i;  op_b = imm_i; end
            RS2_RS1: begin op_a = rs1_i; op_b = rs2_i; end
            default: begin op_a = rs1_i; op_b = rs2_i; end
        endcase
    end

    // One shared 64-bit multiplier; operand extension selects the signedness.
    logic [2*XLEN-1:0] mul_a, mul_b, mul_p;
    logic              mul_a_signed, mul_b_signed;

    always_comb begin
        mul_a_signed = (alu_op_i == ALU_MULH) || (alu_op_i == ALU_MULHSU);
        mul_b_signed = (alu_op_i == ALU_MULH);
        mul_a = mul_a_signed ? {{XLEN{op_a[XLEN-1]}}, op_a} : {{XLEN{1'b0}}, op_a};
        mul_b = mul_b_signed ? {{XLEN{op_b[XLEN-1]}}, op_b} : {{XLEN{1'b0}}, op_b};
        mul_p = mul_a * mul_b;
    end

    logic [XLEN-1:0] alu_comb;

    always_comb begin
        case (alu_op_i)
            ALU_ADD:    alu_comb = op_a + op_b;
            ALU_SUB:    alu_comb = op_a - op_b;
            ALU_AND:    alu_comb = op_a & op_b;
            ALU_OR:     alu_comb = op_a | op_b;
            ALU_XOR:    alu_comb = op_a ^ op_b;
            ALU_SLL:    alu_comb = op_a << op_b[4:0];
            ALU_SRL:    alu_comb = op_a >> op_b[4:0];
            ALU_SRA:    alu_comb = XLEN'($signed(op_a) >>> op_b[4:0]);
            ALU_SLT:    alu_comb = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU:   alu_comb = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_LUI:    alu_comb = op_b;
            ALU_MUL:    alu_comb = mul_p[XLEN-1:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  alu_comb = mul_p[2*XLEN-1:XLEN];
            default:    alu_comb = '0;
        endcase
    end

    logic            br_taken, br_active, br_link;
    logic [XLEN-1:0] br_target, jalr_sum, pc_plus4;

    always_comb begin
        pc_plus4  = pc_i + XLEN'(4);
        jalr_sum  = rs1_i + imm_i;
        br_target = pc_i + imm_i;
        case (br_op_i)
            BR_BEQ:  br_taken = (rs1_i == rs2_i);
            BR_BNE:  br_taken = (rs1_i != rs2_i);
            BR_BLT:  br_taken = ($signed(rs1_i) <  $signed(rs2_i));
            BR_BGE:  br_taken = ($signed(rs1_i) >= $signed(rs2_i));
            BR_BLTU: br_taken = (rs1_i <  rs2_i);
            BR_BGEU: br_taken = (rs1_i >= rs2_i);
            BR_JAL:  br_taken = 1'b1;
            BR_JALR: begin
                br_taken  = 1'b1;
                br_target = jalr_sum & ~XLEN'(1);
            end
            default: br_taken = 1'b0;
        endcase
        br_active    = br_sig_i && (state == S_IDLE);
        br_link      = br_active && ((br_op_i == BR_JAL) || (br_op_i == BR_JALR));
        mispredict_o = br_active && (br_taken != br_pred_i);
        if (mispredict_o)
            redirect_pc_o = br_taken ? br_target : pc_plus4;
        else
            redirect_pc_o = '0;
    end

    // Divider: magnitudes are divided, signs and special cases fixed up at the end.
    logic             is_div_op, is_signed_div, a_neg, b_neg;
    logic [XLEN-1:0]  abs_a, abs_b;
    logic [XLEN-1:0]  div_quo, div_rem, div_dvs;
    logic [CNT_W-1:0] div_cnt;
    logic             div_neg_q, div_neg_r, div_is_rem, div_zero, div_ovf;

    always_comb begin
        is_div_op     = (alu_op_i == ALU_DIV) || (alu_op_i == ALU_DIVU) ||
                        (alu_op_i == ALU_REM) || (alu_op_i == ALU_REMU);
        is_signed_div = (alu_op_i == ALU_DIV) || (alu_op_i == ALU_REM);
        a_neg         = is_signed_div && op_a[XLEN-1];
        b_neg         = is_signed_div && op_b[XLEN-1];
        abs_a         = a_neg ? -op_a : op_a;
        abs_b         = b_neg ? -op_b : op_b;
    end

    logic [XLEN:0]   rem_shift;
    logic [XLEN-1:0] rem_diff, rem_next;
    logic            rem_ge;

    always_comb begin
        rem_shift = {div_rem, div_quo[XLEN-1]};
        rem_ge    = rem_shift >= {1'b0, div_dvs};
        rem_diff  = rem_shift[XLEN-1:0] - div_dvs;
        rem_next  = rem_ge ? rem_diff : rem_shift[XLEN-1:0];
    end

    logic [XLEN-1:0] div_q_res, div_r_res, div_res;

    always_comb begin
        if (div_zero)
            div_q_res = '1;
        else if (div_ovf)
            div_q_res = {1'b1, {(XLEN-1){1'b0}}};
        else
            div_q_res = div_neg_q ? -div_quo : div_quo;
        if (div_ovf)
            div_r_res = '0;
        else
            div_r_res = div_neg_r ? -div_rem : div_rem;
        div_res = div_is_rem ? div_r_res : div_q_res;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            div_quo    <= '0;
            div_rem    <= '0;
            div_dvs    <= '0;
            div_cnt    <= '0;
            div_neg_q  <= 1'b0;
            div_neg_r  <= 1'b0;
            div_is_rem <= 1'b0;
            div_zero   <= 1'b0;
            div_ovf    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_div_op) begin
                        div_quo    <= abs_a;
                        div_rem    <= '0;
                        div_dvs    <= abs_b;
                        div_cnt    <= '0;
                        div_neg_q  <= a_neg ^ b_neg;
                        div_neg_r  <= a_neg;
                        div_is_rem <= (alu_op_i == ALU_REM) || (alu_op_i == ALU_REMU);
                        div_zero   <= (op_b == '0);
                        div_ovf    <= is_signed_div && (op_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                                      (op_b == '1);
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    div_rem <= rem_next;
                    div_quo <= {div_quo[XLEN-2:0], rem_ge};
                    div_cnt <= div_cnt + CNT_W'(1);
                    if (div_cnt == CNT_W'(XLEN-1))
                        state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        stall_o = ((state == S_IDLE) && is_div_op) || (state == S_RUN);
        case (state)
            S_DONE: alu_res_o = div_res;
            S_RUN:  alu_res_o = '0;
            default: begin
                if (is_div_op)
                    alu_res_o = '0;
                else if (br_link)
                    alu_res_o = pc_plus4;
                else
                    alu_res_o = alu_comb;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            mispred_cnt_o <= '0;
        else if (mispredict_o && (mispred_cnt_o != '1))
            mispred_cnt_o <= mispred_cnt_o + MISPRED_CNT_W'(1);
    end

endmodule
